// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: data width, operation encoding and the request bundle
// used by every block that arbitrates access to the single ALU.
package alu_arbiter_pkg;

    localparam int XLEN            = 32;
    localparam int ALU_ARB_NUM_REQ = 2;

    typedef enum logic [3:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL
    } op_alu_e;

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] pc;
        op_alu_e         op;
    } alu_req_t;

    // Occupancy of the one-entry response buffer.
    typedef enum logic {
        EMPTY,
        FULL
    } rsp_state_e;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: grants the first set request found
// searching upward from last_grant+1, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = '0;
        if (enable) begin
            // k = N revisits last_grant itself, so a lone requester is never skipped.
            for (int k = 1; k <= N; k++) begin
                idx = IW'((32'(last_grant) + 32'(k)) % N);
                if (!any_grant && req[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                    any_grant  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ valid/ready requesters and
// registers each result, tagged with its requester id, in a one-entry buffer.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ALU_ARB_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_REQ-1:0]  req_valid_i,
    output logic [NUM_REQ-1:0]  req_ready_o,
    input  logic [XLEN-1:0]     req_in1_i [NUM_REQ],
    input  logic [XLEN-1:0]     req_in2_i [NUM_REQ],
    input  logic [XLEN-1:0]     req_pc_i  [NUM_REQ],
    input  op_alu_e             req_op_i  [NUM_REQ],
    output logic [XLEN-1:0]     alu_in1_o,
    output logic [XLEN-1:0]     alu_in2_o,
    output logic [XLEN-1:0]     alu_pc_o,
    output op_alu_e             alu_op_o,
    input  logic [XLEN-1:0]     alu_out_i,
    input  logic [31:0]         alu_pc_inc_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic [XLEN-1:0]     rsp_out_o,
    output logic [31:0]         rsp_pc_inc_o
);

    alu_req_t         req [NUM_REQ];
    alu_req_t         granted;
    rsp_state_e       state_reg;
    logic [ID_W-1:0]  last_grant_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic [XLEN-1:0]  rsp_out_reg;
    logic [31:0]      rsp_pc_inc_reg;
    logic             can_accept;
    logic             arb_enable;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;
    logic             any_grant;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req[gi] = {req_in1_i[gi], req_in2_i[gi], req_pc_i[gi], req_op_i[gi]};
        end
    endgenerate

    // The buffer slot frees this edge if the consumer takes the current response.
    assign can_accept = (state_reg == EMPTY) || rsp_ready_i;
    assign arb_enable = can_accept && !rst_i;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req        (req_valid_i),
        .last_grant (last_grant_reg),
        .enable     (arb_enable),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    assign req_ready_o = grant;

    always_comb begin
        granted   = '0;
        alu_in1_o = '0;
        alu_in2_o = '0;
        alu_pc_o  = '0;
        alu_op_o  = ALU_NOP;
        if (any_grant) begin
            granted   = req[grant_idx];
            alu_in1_o = granted.in1;
            alu_in2_o = granted.in2;
            alu_pc_o  = granted.pc;
            alu_op_o  = granted.op;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= EMPTY;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            rsp_id_reg     <= '0;
            rsp_out_reg    <= '0;
            rsp_pc_inc_reg <= '0;
        end else if (any_grant) begin
            state_reg      <= FULL;
            last_grant_reg <= grant_idx;
            rsp_id_reg     <= grant_idx;
            rsp_out_reg    <= alu_out_i;
            rsp_pc_inc_reg <= alu_pc_inc_i;
        end else if (state_reg == FULL && rsp_ready_i) begin
            state_reg <= EMPTY;
        end
    end

    assign rsp_valid_o  = (state_reg == FULL);
    assign rsp_id_o     = rsp_id_reg;
    assign rsp_out_o    = rsp_out_reg;
    assign rsp_pc_inc_o = rsp_pc_inc_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with three requesters and a behavioural ALU;
// directed vectors push hand-computed responses, a monitor pops on handshake.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int IDW = $clog2(N);

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [XLEN-1:0] out;
        logic [31:0]     pc_inc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [XLEN-1:0] req_in1 [N];
    logic [XLEN-1:0] req_in2 [N];
    logic [XLEN-1:0] req_pc  [N];
    op_alu_e         req_op  [N];
    logic [XLEN-1:0] alu_in1, alu_in2, alu_pc, alu_out;
    op_alu_e         alu_op;
    logic [31:0]     alu_pc_inc;
    logic            rsp_valid, rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [XLEN-1:0] rsp_out;
    logic [31:0]     rsp_pc_inc;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_in1_i    (req_in1),
        .req_in2_i    (req_in2),
        .req_pc_i     (req_pc),
        .req_op_i     (req_op),
        .alu_in1_o    (alu_in1),
        .alu_in2_o    (alu_in2),
        .alu_pc_o     (alu_pc),
        .alu_op_o     (alu_op),
        .alu_out_i    (alu_out),
        .alu_pc_inc_i (alu_pc_inc),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_out_o    (rsp_out),
        .rsp_pc_inc_o (rsp_pc_inc)
    );

    // Behavioural stand-in for the shared combinational ALU.
    always_comb begin
        case (alu_op)
            ALU_ADD: alu_out = alu_in1 + alu_in2;
            ALU_SUB: alu_out = alu_in1 - alu_in2;
            ALU_AND: alu_out = alu_in1 & alu_in2;
            ALU_OR:  alu_out = alu_in1 | alu_in2;
            ALU_XOR: alu_out = alu_in1 ^ alu_in2;
            ALU_SLL: alu_out = alu_in1 << alu_in2[4:0];
            ALU_SRL: alu_out = alu_in1 >> alu_in2[4:0];
            default: alu_out = '0;
        endcase
    end
    assign alu_pc_inc = alu_pc + 32'd4;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic set_req(input int i, input op_alu_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc);
        req_in1[i]   = a;
        req_in2[i]   = b;
        req_pc[i]    = pc;
        req_op[i]    = op;
        req_valid[i] = 1'b1;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int id, input logic [31:0] out, input logic [31:0] pc);
        exp_t e;
        e.id     = IDW'(id);
        e.out    = out;
        e.pc_inc = pc + 32'd4;
        return e;
    endfunction

    // Monitor: every completed response handshake must match the queue head.
    always @(negedge clk) begin : monitor
        exp_t got;
        exp_t want;
        if (!rst && rsp_valid && rsp_ready) begin
            got = {rsp_id, rsp_out, rsp_pc_inc};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d out=0x%0h pc_inc=0x%0h, required no response",
                         got.id, got.out, got.pc_inc);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d out=0x%0h pc_inc=0x%0h, required id=%0d out=0x%0h pc_inc=0x%0h",
                             got.id, got.out, got.pc_inc, want.id, want.out, want.pc_inc);
                end else begin
                    $display("rsp id=%0d out=0x%0h pc_inc=0x%0h", got.id, got.out, got.pc_inc);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_in1[i] = '0;
            req_in2[i] = '0;
            req_pc[i]  = '0;
            req_op[i]  = ALU_NOP;
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset state; a valid request during reset must not be accepted.
        set_req(0, ALU_ADD, 32'd1, 32'd1, 32'h0);
        #1;
        chk("reset_ready", 96'(req_ready), 96'(3'b000));
        chk("reset_rsp_valid", 96'(rsp_valid), 96'(1'b0));
        chk("reset_rsp_out", 96'(rsp_out), 96'(32'h0));
        chk("reset_rsp_id", 96'(rsp_id), 96'(2'd0));
        chk("reset_rsp_pc_inc", 96'(rsp_pc_inc), 96'(32'h0));
        clr_req(0);

        // Single request: ADD 5+7.
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, ALU_ADD, 32'd5, 32'd7, 32'h100);
        #1;
        chk("single_ready", 96'(req_ready), 96'(3'b001));
        chk("single_alu_in1", 96'(alu_in1), 96'(32'd5));
        sb.push_back(mk(0, 32'd12, 32'h100));
        next_cycle();
        clr_req(0);
        #1;
        chk("single_rsp_valid", 96'(rsp_valid), 96'(1'b1));
        chk("idle_alu_op", 96'(alu_op), 96'(ALU_NOP));
        chk("idle_alu_in1", 96'(alu_in1), 96'(32'h0));
        chk("idle_alu_in2", 96'(alu_in2), 96'(32'h0));
        chk("idle_alu_pc", 96'(alu_pc), 96'(32'h0));
        chk("idle_ready", 96'(req_ready), 96'(3'b000));
        next_cycle();
        chk("idle_drained", 96'(rsp_valid), 96'(1'b0));

        // Two continuous requesters; last grant was 0 so requester 1 goes first.
        set_req(0, ALU_SUB, 32'd10, 32'd3, 32'h200);
        set_req(1, ALU_XOR, 32'hF0, 32'h0F, 32'h300);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("alt_grant", 96'(req_ready), 96'(3'b010));
                sb.push_back(mk(1, 32'hFF, 32'h300));
            end else begin
                chk("alt_grant", 96'(req_ready), 96'(3'b001));
                sb.push_back(mk(0, 32'd7, 32'h200));
            end
            if (k > 0) chk("alt_no_bubble", 96'(rsp_valid), 96'(1'b1));
            next_cycle();
        end
        clr_req(0);
        clr_req(1);
        #1;
        chk("alt_last_valid", 96'(rsp_valid), 96'(1'b1));
        next_cycle();
        chk("alt_drained", 96'(rsp_valid), 96'(1'b0));

        // Back-pressure: hold 0x1234 for three cycles with a competing request.
        set_req(1, ALU_ADD, 32'h1000, 32'h234, 32'h400);
        #1;
        chk("bp_first_grant", 96'(req_ready), 96'(3'b010));
        sb.push_back(mk(1, 32'h1234, 32'h400));
        next_cycle();
        clr_req(1);
        rsp_ready = 1'b0;
        set_req(0, ALU_ADD, 32'd1, 32'd1, 32'h500);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_valid", 96'(rsp_valid), 96'(1'b1));
            chk("bp_out", 96'(rsp_out), 96'(32'h1234));
            chk("bp_id", 96'(rsp_id), 96'(2'd1));
            chk("bp_pc_inc", 96'(rsp_pc_inc), 96'(32'h404));
            chk("bp_ready", 96'(req_ready), 96'(3'b000));
            next_cycle();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 96'(req_ready), 96'(3'b001));
        sb.push_back(mk(0, 32'd2, 32'h500));
        next_cycle();
        clr_req(0);
        next_cycle();
        chk("bp_drained", 96'(rsp_valid), 96'(1'b0));

        // Reset while FULL holding id1 discards it; priority returns to req0.
        rsp_ready = 1'b0;
        set_req(1, ALU_ADD, 32'd3, 32'd4, 32'h600);
        #1;
        chk("rstmid_grant", 96'(req_ready), 96'(3'b010));
        next_cycle();
        clr_req(1);
        #1;
        chk("rstmid_full", 96'(rsp_valid), 96'(1'b1));
        chk("rstmid_id", 96'(rsp_id), 96'(2'd1));
        rst = 1'b1;
        set_req(0, ALU_ADD, 32'd8, 32'd8, 32'h700);
        set_req(1, ALU_SUB, 32'd9, 32'd1, 32'h800);
        #1;
        chk("rstmid_ready", 96'(req_ready), 96'(3'b000));
        next_cycle();
        rst = 1'b0;
        #1;
        chk("rstmid_rsp_valid", 96'(rsp_valid), 96'(1'b0));
        chk("rstmid_rsp_id", 96'(rsp_id), 96'(2'd0));
        chk("rstmid_rsp_out", 96'(rsp_out), 96'(32'h0));
        rsp_ready = 1'b1;
        #1;
        chk("rstmid_first", 96'(req_ready), 96'(3'b001));
        sb.push_back(mk(0, 32'd16, 32'h700));
        next_cycle();
        #1;
        chk("rstmid_second", 96'(req_ready), 96'(3'b010));
        sb.push_back(mk(1, 32'd8, 32'h800));
        next_cycle();
        clr_req(0);
        clr_req(1);
        next_cycle();
        chk("rstmid_drained", 96'(rsp_valid), 96'(1'b0));

        // Three-way rotation; req2 alone first moves last_grant to 2.
        set_req(2, ALU_SLL, 32'd1, 32'd4, 32'h900);
        #1;
        chk("rot_req2_first", 96'(req_ready), 96'(3'b100));
        sb.push_back(mk(2, 32'h10, 32'h900));
        next_cycle();
        set_req(0, ALU_AND, 32'hFF00, 32'h0FF0, 32'hA00);
        set_req(1, ALU_OR, 32'h10, 32'h01, 32'hB00);
        for (int k = 0; k < 6; k++) begin
            #1;
            case (k % 3)
                0: begin
                    chk("rot_grant", 96'(req_ready), 96'(3'b001));
                    sb.push_back(mk(0, 32'h0F00, 32'hA00));
                end
                1: begin
                    chk("rot_grant", 96'(req_ready), 96'(3'b010));
                    sb.push_back(mk(1, 32'h11, 32'hB00));
                end
                default: begin
                    chk("rot_grant", 96'(req_ready), 96'(3'b100));
                    sb.push_back(mk(2, 32'h10, 32'h900));
                end
            endcase
            next_cycle();
        end
        clr_req(0);
        clr_req(1);
        #1;
        chk("rot_req2_after_wrap", 96'(req_ready), 96'(3'b100));
        sb.push_back(mk(2, 32'h10, 32'h900));
        next_cycle();
        clr_req(2);
        next_cycle();
        chk("rot_drained", 96'(rsp_valid), 96'(1'b0));

        for (int i = 0; i < 20 && sb.size() != 0; i++) next_cycle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: got %0d pending responses, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
